// File: rtl/tdm_pkg.sv
// Shared constants and FSM state type for the tdm_demux4 receive path.
package tdm_pkg;
  localparam int LANES  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } tdm_state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the TDM demux: synchronous clear, load-to-1 and increment.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load1_i,
  input  logic              en_i,
  output logic [SLOT_W-1:0] cnt_o
);

  logic [SLOT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = '0;
    else if (load1_i) cnt_d = SLOT_W'(1);
    else if (en_i)    cnt_d = cnt_q + SLOT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// Four-lane TDM demultiplexer: collects slots 0..3 into shadow lanes and commits them to X.
// Optional feature: define TDM_PARITY_EN for a fifth parity beat checked before commit.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [WIDTH-1:0]       in_data,
  output logic [LANES*WIDTH-1:0] X,
  output logic                   out_valid,
  output logic [SLOT_W-1:0]      sel,
  output logic                   frame_err
);

  tdm_state_t              state_q, state_d;
  logic [LANES*WIDTH-1:0]  shadow_q, shadow_d;
  logic [LANES*WIDTH-1:0]  x_q, x_d;
  logic                    ov_q, ov_d;
  logic                    fe_q, fe_d;
  logic                    ctr_clr, ctr_load1, ctr_en;
  logic [SLOT_W-1:0]       sel_cur;

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (ctr_clr),
    .load1_i (ctr_load1),
    .en_i    (ctr_en),
    .cnt_o   (sel_cur)
  );

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    x_d       = x_q;
    ov_d      = 1'b0;
    fe_d      = 1'b0;
    ctr_clr   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_en    = 1'b0;

    if (in_valid) begin
      if (in_sof) begin
        // An SOF outside IDLE aborts the frame in progress and restarts at lane 0.
        fe_d                 = (state_q != IDLE);
        shadow_d             = '0;
        shadow_d[WIDTH-1:0]  = in_data;
        ctr_load1            = 1'b1;
        state_d              = RECV;
      end else begin
        case (state_q)
          RECV: begin
            shadow_d[int'(sel_cur)*WIDTH +: WIDTH] = in_data;
            if (sel_cur == SLOT_W'(LANES-1)) begin
`ifdef TDM_PARITY_EN
              state_d = PAR;
`else
              x_d     = shadow_d;
              ov_d    = 1'b1;
              ctr_clr = 1'b1;
              state_d = IDLE;
`endif
            end else begin
              ctr_en = 1'b1;
            end
          end
`ifdef TDM_PARITY_EN
          PAR: begin
            if (in_data[0] == ^shadow_q) begin
              x_d  = shadow_q;
              ov_d = 1'b1;
            end else begin
              fe_d = 1'b1;
            end
            ctr_clr = 1'b1;
            state_d = IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      x_q      <= '0;
      ov_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      x_q      <= x_d;
      ov_q     <= ov_d;
      fe_q     <= fe_d;
    end
  end

  assign X         = x_q;
  assign out_valid = ov_q;
  assign frame_err = fe_q;
  assign sel       = sel_cur;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (WIDTH=1); honours TDM_PARITY_EN when defined.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [0:0] in_data;
  logic [3:0] X;
  logic       out_valid;
  logic [1:0] sel;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.WIDTH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .X         (X),
    .out_valid (out_valid),
    .sel       (sel),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one accepted beat, then sample just after the edge that takes it.
  task automatic beat(input logic sof, input logic d);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] v, input string tag);
    beat(1'b1, v[0]);
    chk({tag, "_ov_b0"}, out_valid, 0);
    chk({tag, "_sel_b0"}, sel, 1);
    beat(1'b0, v[1]);
    chk({tag, "_ov_b1"}, out_valid, 0);
    chk({tag, "_sel_b1"}, sel, 2);
    beat(1'b0, v[2]);
    chk({tag, "_ov_b2"}, out_valid, 0);
    chk({tag, "_sel_b2"}, sel, 3);
    beat(1'b0, v[3]);
`ifdef TDM_PARITY_EN
    chk({tag, "_ov_b3"}, out_valid, 0);
    chk({tag, "_sel_par"}, sel, 3);
    beat(1'b0, ^v);
`endif
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_x"}, X, v);
    chk({tag, "_sel_end"}, sel, 0);
    chk({tag, "_fe"}, frame_err, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_x", X, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_sel", sel, 0);
    @(negedge clk); rst = 1'b0;

    // Basic frame 1,0,1,1 -> 4'b1101
    send_frame(4'b1101, "basic");
    idle_cycle();
    chk("basic_ov_pulse", out_valid, 0);
    chk("basic_x_hold", X, 4'b1101);

    // Gap of 3 idle cycles after the second beat
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      chk("gap_sel_hold", sel, 2);
      chk("gap_ov", out_valid, 0);
    end
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
`ifdef TDM_PARITY_EN
    beat(1'b0, 1'b1);
`endif
    chk("gap_ov", out_valid, 1);
    chk("gap_x", X, 4'b1101);

    // Early SOF: partial 1,0 then new frame 0,0,1,0
    beat(1'b1, 1'b1);
    chk("esof_ov_clear", out_valid, 0);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    chk("esof_fe", frame_err, 1);
    chk("esof_ov", out_valid, 0);
    chk("esof_x_kept", X, 4'b1101);
    chk("esof_sel", sel, 1);
    beat(1'b0, 1'b0);
    chk("esof_fe_pulse", frame_err, 0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
`ifdef TDM_PARITY_EN
    beat(1'b0, 1'b1);
`endif
    chk("esof_new_ov", out_valid, 1);
    chk("esof_new_x", X, 4'b0100);

    // Non-SOF beats in IDLE are dropped silently
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 1'b1);
      chk("drop_ov", out_valid, 0);
      chk("drop_fe", frame_err, 0);
      chk("drop_x", X, 4'b0100);
      chk("drop_sel", sel, 0);
    end

    // Reset mid-frame discards everything
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    @(negedge clk); rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    @(posedge clk); #1;
    chk("mrst_x", X, 0);
    chk("mrst_sel", sel, 0);
    chk("mrst_ov", out_valid, 0);
    chk("mrst_fe", frame_err, 0);
    @(negedge clk); rst = 1'b0;
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    chk("mrst_after_ov", out_valid, 0);
    chk("mrst_after_sel", sel, 0);
    chk("mrst_after_x", X, 0);

    // Sixteen zero-gap back-to-back frames 0..15
    for (int v = 0; v < 16; v++) begin
      send_frame(4'(v), "b2b");
    end
    idle_cycle();
    chk("b2b_ov_end", out_valid, 0);
    chk("b2b_x_hold", X, 4'hF);

`ifdef TDM_PARITY_EN
    // Good parity: frame 1,1,1,0, parity 1
    beat(1'b1, 1'b1); beat(1'b0, 1'b1); beat(1'b0, 1'b1); beat(1'b0, 1'b0);
    chk("par_sel", sel, 3);
    beat(1'b0, 1'b1);
    chk("par_ok_ov", out_valid, 1);
    chk("par_ok_fe", frame_err, 0);
    chk("par_ok_x", X, 4'b0111);
    // Bad parity: frame 1,0,0,0 needs parity 1, send 0
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    chk("par_bad_fe", frame_err, 1);
    chk("par_bad_ov", out_valid, 0);
    chk("par_bad_x", X, 4'b0111);
    chk("par_bad_sel", sel, 0);
    idle_cycle();
    chk("par_bad_fe_pulse", frame_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
